// File: rtl/fft_mem_ctrl.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT working memory.
// Bit-reversed load, per-stage butterfly read/write pattern, natural-order unload.
module fft_mem_ctrl #(
  parameter int unsigned N    = 16,
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic            bf_done,
  output logic            busy,
  output logic            load_data,
  output logic [SIZE:0]   invert_adr,
  output logic            en_rd_1,
  output logic            en_rd_2,
  output logic [SIZE:0]   rd_ptr,
  output logic            en_wr,
  output logic [SIZE:0]   wr_ptr,
  output logic            wr_sel,
  output logic [SIZE-2:0] twiddle_idx,
  output logic [SIZE-1:0] stage,
  output logic            out_valid,
  output logic            done
);

  typedef logic [SIZE-1:0] cnt_t;
  typedef logic [SIZE:0]   adr_t;
  typedef logic [SIZE-2:0] tw_t;

  typedef enum logic [3:0] {
    StIdle, StLoad, StGap, StReadA, StReadB, StWaitBf, StWriteA, StWriteB, StUnload, StFin
  } state_e;

  localparam cnt_t CntLast   = cnt_t'(N - 1);
  localparam cnt_t PairLast  = cnt_t'(N / 2 - 1);
  localparam cnt_t StageLast = cnt_t'(SIZE - 1);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  cnt_t   s_q, s_d;
  logic   gap_q, gap_d;
  logic   gap_to_unload_q, gap_to_unload_d;

  logic busy_q, busy_d;
  logic load_data_q, load_data_d;
  adr_t invert_adr_q, invert_adr_d;
  logic en_rd_1_q, en_rd_1_d;
  logic en_rd_2_q, en_rd_2_d;
  adr_t rd_ptr_q, rd_ptr_d;
  logic en_wr_q, en_wr_d;
  adr_t wr_ptr_q, wr_ptr_d;
  logic wr_sel_q, wr_sel_d;
  tw_t  twiddle_q, twiddle_d;
  cnt_t stage_q, stage_d;
  logic out_valid_q, out_valid_d;
  logic done_q, done_d;

  cnt_t cnt_rev;
  adr_t h, mask, p_ext, adr_a, adr_b;

  always_comb begin
    cnt_rev = '0;
    for (int i = 0; i < SIZE; i++) begin
      cnt_rev[i] = cnt_q[SIZE-1-i];
    end
  end

  // Butterfly pair addresses: insert a zero bit at position s of the pair index.
  always_comb begin
    h     = adr_t'(1) << s_q;
    mask  = h - adr_t'(1);
    p_ext = {1'b0, cnt_q};
    adr_a = ((p_ext & ~mask) << 1) | (p_ext & mask);
    adr_b = adr_a | h;
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    s_d             = s_q;
    gap_d           = gap_q;
    gap_to_unload_d = gap_to_unload_q;

    busy_d       = (state_q != StIdle);
    load_data_d  = 1'b0;
    invert_adr_d = '0;
    en_rd_1_d    = 1'b0;
    en_rd_2_d    = 1'b0;
    rd_ptr_d     = '0;
    en_wr_d      = 1'b0;
    wr_ptr_d     = '0;
    wr_sel_d     = 1'b0;
    twiddle_d    = tw_t'(p_ext & mask) << (StageLast - s_q);
    stage_d      = s_q;
    // Delayed read strobe lines up with the memory's read data.
    out_valid_d  = en_rd_1_q & ((state_q == StUnload) || (state_q == StFin));
    done_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          load_data_d  = 1'b1;
          invert_adr_d = {1'b0, cnt_rev};
          cnt_d        = cnt_q + cnt_t'(1);
          if (cnt_q == CntLast) begin
            state_d         = StGap;
            cnt_d           = '0;
            s_d             = '0;
            gap_d           = 1'b0;
            gap_to_unload_d = 1'b0;
          end
        end
      end
      StGap: begin
        if (gap_q) begin
          gap_d   = 1'b0;
          state_d = gap_to_unload_q ? StUnload : StReadA;
        end else begin
          gap_d = 1'b1;
        end
      end
      StReadA: begin
        en_rd_1_d = 1'b1;
        rd_ptr_d  = adr_a;
        state_d   = StReadB;
      end
      StReadB: begin
        en_rd_2_d = 1'b1;
        rd_ptr_d  = adr_b;
        state_d   = StWaitBf;
      end
      StWaitBf: begin
        if (bf_done) begin
          state_d = StWriteA;
        end
      end
      StWriteA: begin
        en_wr_d  = 1'b1;
        wr_ptr_d = adr_a;
        wr_sel_d = 1'b0;
        state_d  = StWriteB;
      end
      StWriteB: begin
        en_wr_d  = 1'b1;
        wr_ptr_d = adr_b;
        wr_sel_d = 1'b1;
        if (cnt_q != PairLast) begin
          cnt_d   = cnt_q + cnt_t'(1);
          state_d = StReadA;
        end else begin
          cnt_d   = '0;
          gap_d   = 1'b0;
          state_d = StGap;
          if (s_q != StageLast) begin
            s_d = s_q + cnt_t'(1);
          end else begin
            gap_to_unload_d = 1'b1;
          end
        end
      end
      StUnload: begin
        en_rd_1_d = 1'b1;
        rd_ptr_d  = {1'b0, cnt_q};
        cnt_d     = cnt_q + cnt_t'(1);
        if (cnt_q == CntLast) begin
          state_d = StFin;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      s_q             <= '0;
      gap_q           <= 1'b0;
      gap_to_unload_q <= 1'b0;
      busy_q          <= 1'b0;
      load_data_q     <= 1'b0;
      invert_adr_q    <= '0;
      en_rd_1_q       <= 1'b0;
      en_rd_2_q       <= 1'b0;
      rd_ptr_q        <= '0;
      en_wr_q         <= 1'b0;
      wr_ptr_q        <= '0;
      wr_sel_q        <= 1'b0;
      twiddle_q       <= '0;
      stage_q         <= '0;
      out_valid_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      s_q             <= s_d;
      gap_q           <= gap_d;
      gap_to_unload_q <= gap_to_unload_d;
      busy_q          <= busy_d;
      load_data_q     <= load_data_d;
      invert_adr_q    <= invert_adr_d;
      en_rd_1_q       <= en_rd_1_d;
      en_rd_2_q       <= en_rd_2_d;
      rd_ptr_q        <= rd_ptr_d;
      en_wr_q         <= en_wr_d;
      wr_ptr_q        <= wr_ptr_d;
      wr_sel_q        <= wr_sel_d;
      twiddle_q       <= twiddle_d;
      stage_q         <= stage_d;
      out_valid_q     <= out_valid_d;
      done_q          <= done_d;
    end
  end

  assign busy        = busy_q;
  assign load_data   = load_data_q;
  assign invert_adr  = invert_adr_q;
  assign en_rd_1     = en_rd_1_q;
  assign en_rd_2     = en_rd_2_q;
  assign rd_ptr      = rd_ptr_q;
  assign en_wr       = en_wr_q;
  assign wr_ptr      = wr_ptr_q;
  assign wr_sel      = wr_sel_q;
  assign twiddle_idx = twiddle_q;
  assign stage       = stage_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Randomised bench for fft_mem_ctrl: expected strobe/address stream is built from
// the transform's address rules, then matched cycle by cycle against the outputs.
module tb_fft_mem_ctrl;
  localparam int N    = 16;
  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            rst_n, start, in_valid, bf_done;
  logic            busy, load_data, en_rd_1, en_rd_2, en_wr, wr_sel, out_valid, done;
  logic [SIZE:0]   invert_adr, rd_ptr, wr_ptr;
  logic [SIZE-2:0] twiddle_idx;
  logic [SIZE-1:0] stage;

  fft_mem_ctrl #(.N(N), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .bf_done(bf_done),
    .busy(busy), .load_data(load_data), .invert_adr(invert_adr), .en_rd_1(en_rd_1),
    .en_rd_2(en_rd_2), .rd_ptr(rd_ptr), .en_wr(en_wr), .wr_ptr(wr_ptr), .wr_sel(wr_sel),
    .twiddle_idx(twiddle_idx), .stage(stage), .out_valid(out_valid), .done(done)
  );

  always #5 clk = ~clk;

  // kind: 0 load, 1 read A, 2 read B, 3 write A, 4 write B, 5 unload read
  // dly: required cycles since the previous strobe (0 = checked elsewhere)
  typedef struct { int kind; int addr; int tw; int stg; int dly; } ev_t;
  ev_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < SIZE; i++) if (v[i]) r |= 1 << (SIZE - 1 - i);
    return r;
  endfunction

  task automatic build_model();
    int h, a, tw;
    exp_q.delete();
    for (int c = 0; c < N; c++) exp_q.push_back('{0, bitrev(c), 0, 0, 0});
    for (int s = 0; s < SIZE; s++) begin
      for (int p = 0; p < N / 2; p++) begin
        h  = 1 << s;
        a  = ((p >> s) << (s + 1)) | (p & (h - 1));
        tw = (p & (h - 1)) << (SIZE - 1 - s);
        exp_q.push_back('{1, a,     tw, s, (p == 0) ? 3 : 1});
        exp_q.push_back('{2, a + h, tw, s, 1});
        exp_q.push_back('{3, a,     tw, s, 0});
        exp_q.push_back('{4, a + h, tw, s, 1});
      end
    end
    for (int c = 0; c < N; c++) exp_q.push_back('{5, c, 0, 0, (c == 0) ? 3 : 1});
  endtask

  task automatic run_transform(input int stall_pair, input bit spurious, input bit abort_mid);
    ev_t  e;
    int   nstr, obs_kind, exp_kind, last_str, loads_fed, cd, exp_wr, pairs, wrb_s2, stall_tw;
    int   n_ov;
    bit   prev_iv, prev_unl, prev_unl_last, prev_done, stall_win, sp_start, unl_seen, rda_now;
    bit   finished;
    logic [SIZE:0]   obs_a, exp_a;
    logic [SIZE-2:0] exp_tw;
    logic [SIZE-1:0] exp_stg;
    build_model();
    last_str = -100; loads_fed = 0; cd = 0; exp_wr = -1; pairs = 0; wrb_s2 = 0; stall_tw = 0;
    n_ov = 0; prev_iv = 0; prev_unl = 0; prev_unl_last = 0; prev_done = 0; stall_win = 0;
    sp_start = 0; unl_seen = 0; finished = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      rda_now = 0;
      nstr = int'(load_data) + int'(en_rd_1) + int'(en_rd_2) + int'(en_wr);
      n_total++;
      if (nstr > 1) $display("FAIL one_strobe cyc %0d got %0d strobes need <=1", cyc, nstr);
      else n_pass++;
      if (prev_done) begin
        n_total++;
        if ({busy, done} !== 2'b00 || exp_q.size() != 0)
          $display("FAIL end_state busy/done got %b%b left %0d need 00/0", busy, done,
                   exp_q.size());
        else n_pass++;
        finished = 1;
      end else if (nstr != 0) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL extra_strobe cyc %0d got strobe need none", cyc);
        end else begin
          e = exp_q.pop_front();
          obs_kind = load_data ? 0 : en_rd_1 ? 1 : en_rd_2 ? 2 : wr_sel ? 4 : 3;
          exp_kind = (e.kind == 5) ? 1 : e.kind;
          obs_a = load_data ? invert_adr : (en_rd_1 || en_rd_2) ? rd_ptr : wr_ptr;
          exp_a = e.addr[SIZE:0];
          n_total++;
          if (obs_kind != exp_kind || obs_a !== exp_a || busy !== 1'b1)
            $display("FAIL strobe cyc %0d got kind %0d adr %0d busy %b need kind %0d adr %0d",
                     cyc, obs_kind, obs_a, busy, exp_kind, exp_a);
          else n_pass++;
          if (e.kind >= 1 && e.kind <= 4) begin
            exp_tw = e.tw[SIZE-2:0]; exp_stg = e.stg[SIZE-1:0];
            n_total++;
            if (twiddle_idx !== exp_tw || stage !== exp_stg)
              $display("FAIL twiddle_stage cyc %0d got %0d/%0d need %0d/%0d", cyc, twiddle_idx,
                       stage, exp_tw, exp_stg);
            else n_pass++;
          end
          n_total++;
          if (e.dly > 0 && cyc - last_str != e.dly)
            $display("FAIL spacing kind %0d got %0d need %0d", e.kind, cyc - last_str, e.dly);
          else if (e.kind == 0 && !prev_iv)
            $display("FAIL load_timing cyc %0d got load without in_valid need in_valid", cyc);
          else if (e.kind == 3 && cyc != exp_wr)
            $display("FAIL write_a_timing got cyc %0d need %0d", cyc, exp_wr);
          else n_pass++;
          if (e.kind == 1) rda_now = 1;
          if (e.kind == 2) begin
            cd = ((pairs == stall_pair) ? 20 : $urandom_range(2, 5)) + 1;
            stall_win = 1; stall_tw = e.tw; pairs++;
          end
          if (e.kind == 3) stall_win = 0;
          if (e.kind == 4 && e.stg == 2) wrb_s2++;
          if (e.kind == 5) unl_seen = 1;
        end
        last_str = cyc;
      end else if (stall_win) begin
        exp_tw = stall_tw[SIZE-2:0];
        n_total++;
        if (twiddle_idx !== exp_tw)
          $display("FAIL stall_twiddle cyc %0d got %0d need %0d", cyc, twiddle_idx, exp_tw);
        else n_pass++;
      end
      n_total++;
      if (out_valid !== prev_unl || done !== prev_unl_last)
        $display("FAIL valid_done cyc %0d got %b/%b need %b/%b", cyc, out_valid, done,
                 prev_unl, prev_unl_last);
      else n_pass++;
      if (out_valid === 1'b1) n_ov++;
      prev_done = prev_unl_last;
      prev_unl = (nstr != 0) && en_rd_1 && (e.kind == 5);
      prev_unl_last = prev_unl && (e.addr == N - 1);

      if (abort_mid && wrb_s2 == 3) begin
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, load_data, invert_adr, en_rd_1, en_rd_2, rd_ptr, en_wr, wr_ptr, wr_sel,
             twiddle_idx, stage, out_valid, done} !== '0)
          $display("FAIL reset_mid outputs got nonzero need all 0 (stage %0d)", stage);
        else n_pass++;
        in_valid = 1'b0; bf_done = 1'b0; start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        return;
      end

      // Drive this cycle's inputs.
      in_valid = 1'b0; bf_done = 1'b0; start = 1'b0;
      if (loads_fed < N && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; loads_fed++;
      end
      if (spurious && loads_fed == 5 && !sp_start) begin
        start = 1'b1; sp_start = 1;
      end
      if (spurious && unl_seen && !prev_done) in_valid = 1'($urandom_range(0, 1));
      if (spurious && rda_now) bf_done = 1'b1;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bf_done = 1'b1; exp_wr = cyc + 2;
        end
      end
      prev_iv = in_valid && (loads_fed <= N) && !unl_seen;
      @(negedge clk);
    end
    n_total++;
    if (!finished) $display("FAIL timeout got no done within budget need done");
    else if (n_ov != N) $display("FAIL out_valid_count got %0d need %0d", n_ov, N);
    else n_pass++;
    in_valid = 1'b0; bf_done = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; bf_done = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, load_data, invert_adr, en_rd_1, en_rd_2, rd_ptr, en_wr, wr_ptr, wr_sel,
         twiddle_idx, stage, out_valid, done} !== '0)
      $display("FAIL reset_outputs got nonzero need all 0");
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_busy got %b need 0", busy);
    else n_pass++;
  endtask

  task automatic test_full_run();       run_transform(5, 1'b0, 1'b0);  endtask
  task automatic test_spurious();       run_transform(-1, 1'b1, 1'b0); endtask
  task automatic test_reset_midstage(); run_transform(-1, 1'b0, 1'b1); endtask
  task automatic test_restart();        run_transform(12, 1'b0, 1'b0); endtask

  initial begin
    test_reset();
    test_full_run();
    test_spurious();
    test_reset_midstage();
    test_restart();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
